// File: rtl/truth_table_sweep_if.sv
// Handshake and vector bus between a sweep requester and the truth-table sweep engine.
// The requester (master) supplies start/abort, the expected truth table and the
// DUT output; the sweep engine (slave) returns the stimulus and the sweep results.
interface truth_table_sweep_if #(
  parameter int N_IN  = 4,
  parameter int CNT_W = 8
);
  logic                 start;
  logic                 abort;
  logic [2**N_IN-1:0]   expected_tt;
  logic                 dut_f;
  logic [N_IN-1:0]      stim;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [CNT_W-1:0]     err_count;
  logic [N_IN-1:0]      first_fail_idx;
  logic                 first_fail_valid;

  modport master (
    output start, abort, expected_tt, dut_f,
    input  stim, busy, done, pass, err_count, first_fail_idx, first_fail_valid
  );

  modport slave (
    input  start, abort, expected_tt, dut_f,
    output stim, busy, done, pass, err_count, first_fail_idx, first_fail_valid
  );
endinterface

// File: rtl/truth_table_sweep.sv
// Exhaustive truth-table sweeper: drives every N_IN-bit input vector to a DUT for
// DWELL cycles, compares the DUT output against a latched expected truth table on
// the last dwell cycle of each vector, and reports mismatch count, first failing
// vector and an overall pass flag.
module truth_table_sweep #(
  parameter int N_IN  = 4,
  parameter int DWELL = 30,
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  truth_table_sweep_if.slave bus
);

  localparam int N_VEC = 2**N_IN;
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [N_IN-1:0] STIM_LAST  = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_VEC-1:0]   tt_q;
  logic [N_IN-1:0]    stim_q, stim_d;
  logic [DW_W-1:0]    dwell_q, dwell_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [N_IN-1:0]    ffi_q, ffi_d;
  logic               ffv_q, ffv_d;
  logic               pass_q, pass_d;

  logic               accept_start;
  logic               drive_abort;
  logic               compare_en;
  logic               mismatch;
  logic               last_vec;

  // Saturating increment so a long run of failures never wraps back to a small count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  // Qualifiers shared by the FSM and the result datapath. Abort masks the compare.
  assign accept_start = (state_q == S_IDLE) && bus.start;
  assign drive_abort  = (state_q == S_DRIVE) && bus.abort;
  assign compare_en   = (state_q == S_DRIVE) && !bus.abort && (dwell_q == DWELL_LAST);
  assign mismatch     = compare_en && (bus.dut_f != tt_q[stim_q]);
  assign last_vec     = (stim_q == STIM_LAST);

  // State register; reset forces IDLE immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DRIVE ends on the final compare or on abort; DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (compare_en && last_vec) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded purely from the current state.
  always_comb begin
    bus.busy = (state_q == S_DRIVE);
    bus.done = (state_q == S_DONE);
  end

  // Next values for the stimulus, dwell counter and sweep results.
  always_comb begin
    stim_d  = stim_q;
    dwell_d = dwell_q;
    err_d   = err_q;
    ffi_d   = ffi_q;
    ffv_d   = ffv_q;
    pass_d  = pass_q;
    if (accept_start) begin
      stim_d  = '0;
      dwell_d = '0;
      err_d   = '0;
      ffi_d   = '0;
      ffv_d   = 1'b0;
      pass_d  = 1'b0;
    end else if (drive_abort) begin
      // Cancelled sweep: results so far stay visible, but it never counts as a pass.
      stim_d  = '0;
      dwell_d = '0;
      pass_d  = 1'b0;
    end else if (compare_en) begin
      if (mismatch) begin
        err_d = sat_inc(err_q);
        if (!ffv_q) begin
          ffi_d = stim_q;
          ffv_d = 1'b1;
        end
      end
      dwell_d = '0;
      if (last_vec) begin
        // Final compare: pass must include this last vector's result.
        stim_d = '0;
        pass_d = (err_d == '0);
      end else begin
        stim_d = stim_q + N_IN'(1);
      end
    end else if (state_q == S_DRIVE) begin
      dwell_d = dwell_q + DW_W'(1);
    end
  end

  // Result and stimulus registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim_q  <= '0;
      dwell_q <= '0;
      err_q   <= '0;
      ffi_q   <= '0;
      ffv_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      stim_q  <= stim_d;
      dwell_q <= dwell_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
    end
  end

  // Expected truth table snapshot; later changes on the input cannot disturb a sweep.
  always_ff @(posedge clk) begin
    if (accept_start) begin
      tt_q <= bus.expected_tt;
    end
  end

  assign bus.stim             = stim_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail_idx   = ffi_q;
  assign bus.first_fail_valid = ffv_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep with a 4-input AND gate as the device under test.
module tb_truth_table_sweep;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  truth_table_sweep_if #(.N_IN(4), .CNT_W(8)) bus_a ();
  truth_table_sweep_if #(.N_IN(4), .CNT_W(2)) bus_b ();
  truth_table_sweep_if #(.N_IN(4), .CNT_W(8)) bus_c ();

  truth_table_sweep #(.N_IN(4), .DWELL(3), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  truth_table_sweep #(.N_IN(4), .DWELL(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );
  truth_table_sweep #(.N_IN(4), .DWELL(1), .CNT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c)
  );

  // The DUT under test: 4-input AND, stim MSB is the first input.
  assign bus_a.dut_f = &bus_a.stim;
  assign bus_b.dut_f = &bus_b.stim;
  assign bus_c.dut_f = &bus_c.stim;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int err;
    int ffi;
    int ffv;
    int pass;
    int cycles;
  } exp_t;

  exp_t sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference result of sweeping the first n_vec vectors of an AND gate against tt.
  function automatic exp_t model(input logic [15:0] tt, input int n_vec, input int cnt_max,
                                 input int dwell);
    exp_t e;
    logic f;
    e.err = 0;
    e.ffi = 0;
    e.ffv = 0;
    for (int i = 0; i < n_vec; i++) begin
      f = (i == 15);
      if (f != tt[i]) begin
        if (e.err < cnt_max) e.err++;
        if (e.ffv == 0) begin
          e.ffi = i;
          e.ffv = 1;
        end
      end
    end
    e.pass   = (e.err == 0) ? 1 : 0;
    e.cycles = 16 * dwell;
    return e;
  endfunction

  // Full sweep on instance A with optional mid-sweep start pulse, expected_tt change
  // and a start pulse during the DONE cycle.
  task automatic run_a(input logic [15:0] tt, input int start_at, input int tt_chg_at,
                       input bit start_in_done);
    exp_t e;
    int cyc;
    int bad;
    sb_q.push_back(model(tt, 16, 255, 3));
    @(negedge clk);
    bus_a.expected_tt = tt;
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    check_val("a_busy_rise", bus_a.busy, 1);
    cyc = 0;
    bad = 0;
    while (!bus_a.done && cyc < 200) begin
      if (bus_a.stim !== 4'(cyc / 3)) bad++;
      bus_a.start = (start_at >= 0 && int'(bus_a.stim) == start_at && (cyc % 3) == 0);
      if (tt_chg_at >= 0 && int'(bus_a.stim) == tt_chg_at) bus_a.expected_tt = ~tt;
      @(negedge clk);
      cyc++;
    end
    bus_a.start = 1'b0;
    e = sb_q.pop_front();
    check_val("a_done_latency", cyc, e.cycles);
    check_val("a_stim_seq", bad, 0);
    check_val("a_busy_in_done", bus_a.busy, 0);
    check_val("a_err_count", bus_a.err_count, e.err);
    check_val("a_ff_idx", bus_a.first_fail_idx, e.ffi);
    check_val("a_ff_valid", bus_a.first_fail_valid, e.ffv);
    check_val("a_pass", bus_a.pass, e.pass);
    if (start_in_done) bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    check_val("a_done_one_cycle", bus_a.done, 0);
    check_val("a_idle_after_done", bus_a.busy, 0);
    check_val("a_pass_hold", bus_a.pass, e.pass);
    check_val("a_err_hold", bus_a.err_count, e.err);
    @(negedge clk);
    check_val("a_no_restart", bus_a.busy, 0);
  endtask

  initial begin
    exp_t e;
    int n;
    int done_seen;
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.expected_tt = '0;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.expected_tt = '0;
    bus_c.start = 1'b0; bus_c.abort = 1'b0; bus_c.expected_tt = '0;
    rst_n = 1'b0;
    #12;
    check_val("rst_busy", bus_a.busy, 0);
    check_val("rst_done", bus_a.done, 0);
    check_val("rst_pass", bus_a.pass, 0);
    check_val("rst_err", bus_a.err_count, 0);
    check_val("rst_stim", bus_a.stim, 0);
    check_val("rst_ffv", bus_a.first_fail_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Correct table: pass; start during DONE must be ignored.
    run_a(16'h8000, -1, -1, 1'b1);
    // Wrong table: 14 mismatches, first at vector 1.
    run_a(16'hFFFE, -1, -1, 1'b0);
    // Start at stim 7 ignored; expected_tt change at stim 3 ignored.
    run_a(16'hFFFE, 7, 3, 1'b0);

    // Abort at stim 5.
    @(negedge clk);
    bus_a.expected_tt = 16'hFFFE;
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    n = 0;
    while (bus_a.stim != 4'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("abort_reach_stim5", (n < 100), 1);
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.abort = 1'b0;
    e = model(16'hFFFE, 5, 255, 3);
    check_val("abort_busy", bus_a.busy, 0);
    check_val("abort_stim", bus_a.stim, 0);
    check_val("abort_done", bus_a.done, 0);
    check_val("abort_pass", bus_a.pass, 0);
    check_val("abort_err_hold", bus_a.err_count, e.err);
    check_val("abort_ff_idx", bus_a.first_fail_idx, e.ffi);
    check_val("abort_ff_valid", bus_a.first_fail_valid, e.ffv);
    done_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus_a.done || bus_a.busy) done_seen++;
    end
    check_val("abort_no_done", done_seen, 0);
    // Abort while idle does nothing.
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.abort = 1'b0;
    @(negedge clk);
    check_val("idle_abort_busy", bus_a.busy, 0);
    check_val("idle_abort_err", bus_a.err_count, e.err);

    // Asynchronous reset at stim 9, between clock edges.
    @(negedge clk);
    bus_a.expected_tt = 16'hFFFE;
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    n = 0;
    while (bus_a.stim != 4'd9 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("rst_reach_stim9", (n < 100), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_busy", bus_a.busy, 0);
    check_val("arst_stim", bus_a.stim, 0);
    check_val("arst_err", bus_a.err_count, 0);
    check_val("arst_ffv", bus_a.first_fail_valid, 0);
    check_val("arst_ffi", bus_a.first_fail_idx, 0);
    check_val("arst_pass", bus_a.pass, 0);
    check_val("arst_done", bus_a.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_a(16'h8000, -1, -1, 1'b0);

    // Instance B: 2-bit counter saturates.
    sb_q.push_back(model(16'hFFFE, 16, 3, 3));
    @(negedge clk);
    bus_b.expected_tt = 16'hFFFE;
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    n = 0;
    while (!bus_b.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    e = sb_q.pop_front();
    check_val("b_done_latency", n, e.cycles);
    check_val("b_err_sat", bus_b.err_count, e.err);
    check_val("b_ff_idx", bus_b.first_fail_idx, e.ffi);
    check_val("b_pass", bus_b.pass, e.pass);

    // Instance C: DWELL=1 compares every cycle.
    sb_q.push_back(model(16'h8000, 16, 255, 1));
    @(negedge clk);
    bus_c.expected_tt = 16'h8000;
    bus_c.start = 1'b1;
    @(negedge clk);
    bus_c.start = 1'b0;
    n = 0;
    while (!bus_c.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    e = sb_q.pop_front();
    check_val("c_done_latency", n, e.cycles);
    check_val("c_err", bus_c.err_count, e.err);
    check_val("c_pass", bus_c.pass, e.pass);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_sweep.md
TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 SHALL provide parameter N_IN, default 4, meaning number of DUT inputs swept (1..8).
REQ-002 SHALL provide parameter DWELL, default 30, meaning clock cycles each input vector is held (>=1).
REQ-003 SHALL provide parameter CNT_W, default 8, meaning mismatch counter width.
REQ-004 SHALL provide port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL provide port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL provide port start, input, 1, meaning begin a sweep; sampled in IDLE only.
REQ-007 SHALL provide port abort, input, 1, meaning synchronous sweep cancel.
REQ-008 SHALL provide port expected_tt, input, 2**N_IN, meaning expected DUT output; bit i is the expected F for vector i.
REQ-009 SHALL provide port dut_f, input, 1, meaning the DUT output under test.
REQ-010 SHALL provide port stim, output, N_IN, meaning the vector driven to the DUT, MSB = first DUT input.
REQ-011 SHALL provide port busy, output, 1, meaning a sweep is in progress.
REQ-012 SHALL provide port done, output, 1, meaning a one-cycle pulse on sweep completion.
REQ-013 SHALL provide port pass, output, 1, meaning the last completed sweep had zero mismatches.
REQ-014 SHALL provide port err_count, output, CNT_W, meaning mismatches in the current or last sweep.
REQ-015 SHALL provide port first_fail_idx, output, N_IN, meaning the vector of the first mismatch.
REQ-016 SHALL provide port first_fail_valid, output, 1, meaning first_fail_idx holds a captured value.

Function
REQ-017 SHALL implement FSM states IDLE, DRIVE and DONE; all registers SHALL be clocked by clk.
REQ-018 IDLE with start=1 SHALL latch expected_tt, set stim=0, dwell counter=0, err_count=0, first_fail_valid=0 and pass=0, then enter DRIVE; busy=1 from the next cycle.
REQ-019 DRIVE SHALL hold stim constant while the dwell counter counts 0..DWELL-1.
REQ-020 When the dwell counter equals DWELL-1, DRIVE SHALL compare dut_f to latched_tt[stim] in that cycle.
REQ-021 On a mismatch, err_count SHALL increment, saturating at 2**CNT_W-1.
REQ-022 On the first mismatch of a sweep, first_fail_idx SHALL be set to stim and first_fail_valid to 1; later mismatches SHALL NOT alter either.
REQ-023 After each compare, the FSM SHALL enter DONE if stim == 2**N_IN-1; otherwise stim SHALL increment and the dwell counter clear.
REQ-024 Sweep length SHALL be exactly 2**N_IN*DWELL cycles in DRIVE; DWELL=1 SHALL compare every cycle.
REQ-025 DONE SHALL last one cycle with done=1, busy=0 and pass=(err_count==0 including the final compare), then return to IDLE.
REQ-026 pass, err_count, first_fail_idx and first_fail_valid SHALL hold until the next accepted start or reset.
REQ-027 start while busy or in DONE SHALL be ignored.
REQ-028 abort=1 in DRIVE SHALL enter IDLE next cycle with stim=0, busy=0, no done pulse and pass=0; err_count and first_fail_* SHALL hold.
REQ-029 abort SHALL take priority over the compare and advance in the same cycle; abort in IDLE SHALL have no effect.
REQ-030 A change on expected_tt during a sweep SHALL NOT affect the sweep.

Reset
REQ-031 rst_n=0 SHALL immediately, regardless of clk, force IDLE with stim=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=0, first_fail_valid=0 and dwell counter=0.
REQ-032 A reset mid-sweep SHALL discard the sweep; the first start after rst_n deasserts SHALL begin at stim=0.

Verification (N_IN=4, DWELL=3 unless stated)
REQ-033 A bench SHALL cover: expected_tt=16'h8000 with a 4-input AND DUT -> done pulses 48 cycles after busy rises, pass=1, err_count=0, first_fail_valid=0.
REQ-034 A bench SHALL cover: expected_tt=16'hFFFE with the AND DUT -> err_count=14, first_fail_idx=4'b0001, pass=0.
REQ-035 A bench SHALL cover: start pulsed at stim=7 mid-sweep -> no restart; sweep ends after 48 cycles as normal.
REQ-036 A bench SHALL cover: abort at stim=5 -> IDLE next cycle, stim=0, busy=0, no done pulse.
REQ-037 A bench SHALL cover: rst_n low at stim=9 between clock edges -> all outputs zero before the next edge.
REQ-038 A bench SHALL cover: CNT_W=2 with 14 mismatches -> err_count saturates at 3; DWELL=1 -> done 16 cycles after start.
